allpass_filter: RTL and testbench

Schroeder all-pass diffusion stage of the reverb. It consumes the summed output of the comb-filter bank once per audio sample and produces one output word per sample. It runs in the system clock domain, paced by a one-cycle sample strobe. The block has an internal circular delay line and a single shared multiplier sequenced by an FSM.

---
 rtl/allpass_filter.sv | 223 ++++++++++++++++++++++
 tb/tb_allpass_filter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/allpass_filter.sv
// Schroeder all-pass diffusion stage: y = d - g*x, v = x + g*y, v pushed into a circular delay line.
// Latency: sample accepted at edge E0 -> out/out_valid updated at edge E4; at most one sample per 5 clocks.
// No backpressure: sample_en while busy is dropped (flagged by sticky overrun outside CLEAR).

`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

module allpass_filter #(
    parameter int WIDTH    = 24,
    parameter int FRAC     = `FIXED_POINT,
    parameter int MAXDELAY = 4096,
    localparam int WORD    = WIDTH + FRAC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_en,
    input  logic [WORD-1:0] in,
    input  logic [WORD-1:0] tau,
    input  logic [WORD-1:0] gain,
    input  logic            write,
    output logic [WORD-1:0] out,
    output logic            out_valid,
    output logic            busy,
    output logic            overrun
);

    localparam int AW = $clog2(MAXDELAY);

    typedef logic signed [WORD-1:0]   word_t;
    typedef logic signed [2*WORD-1:0] wide_t;

    localparam word_t T_MIN = word_t'(1);
    localparam word_t T_MAX = word_t'(MAXDELAY);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_MUL1,
        S_MUL2,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    // Delay length is kept modulo MAXDELAY: a delay of MAXDELAY reads the
    // slot about to be overwritten, which is the oldest stored sample.
    logic [AW-1:0] shadow_t_q;
    word_t         shadow_g_q;
    logic [AW-1:0] tau_clamped;

    logic [AW-1:0] clr_q;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rd_addr;

    word_t g_q, x_q, d_q, y_q, p_q, out_q, rd_dat_q;
    logic  out_valid_q, overrun_q;

    word_t mem [MAXDELAY];

    logic          accept;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    word_t         ram_wdat;

    word_t mul_b;
    wide_t prod;
    word_t prod_sat, y_calc, v_calc;

    function automatic wide_t ext(input word_t w);
        return {{WORD{w[WORD-1]}}, w};
    endfunction

    // Values fit in WORD only when the top WORD+1 bits are all copies of the sign.
    function automatic word_t sat_w(input wide_t v);
        logic [WORD:0] top;
        top = v[2*WORD-1:WORD-1];
        if ((&top) || !(|top)) begin
            sat_w = v[WORD-1:0];
        end else if (v[2*WORD-1]) begin
            sat_w = {1'b1, {(WORD-1){1'b0}}};
        end else begin
            sat_w = {1'b0, {(WORD-1){1'b1}}};
        end
    endfunction

    // Clamp the requested delay into 1..MAXDELAY (tau treated as signed).
    always_comb begin
        tau_clamped = tau[AW-1:0];
        if ($signed(tau) < T_MIN) begin
            tau_clamped = AW'(1);
        end else if ($signed(tau) > T_MAX) begin
            tau_clamped = '0;
        end
    end

    // Single shared multiplier: g*x in MUL1, g*y in MUL2; all sums saturate.
    always_comb begin
        mul_b    = (state_q == S_MUL2) ? y_q : x_q;
        prod     = ext(g_q) * ext(mul_b);
        prod_sat = sat_w(prod >>> FRAC);
        y_calc   = sat_w(ext(d_q) - ext(prod_sat));
        v_calc   = sat_w(ext(x_q) + ext(p_q));
        rd_addr  = wp_q - shadow_t_q;
    end

    // Next-state logic and RAM write-port steering.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wp_q;
        ram_wdat  = v_calc;
        case (state_q)
            S_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_q;
                ram_wdat  = '0;
                if (clr_q == AW'(MAXDELAY - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (sample_en) begin
                    accept  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_MUL1;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_WRITE;
            S_WRITE: begin
                ram_we  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_CLEAR;
        endcase
        if (rst) begin
            accept = 1'b0;
            ram_we = 1'b0;
        end
    end

    // State register; reset always restarts the delay-line clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow configuration; only copied into the datapath when a sample is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_t_q <= AW'(1);
            shadow_g_q <= '0;
        end else if (write) begin
            shadow_t_q <= tau_clamped;
            shadow_g_q <= gain;
        end
    end

    // Delay-line RAM: one write port, registered read issued at sample accept.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdat;
        end
        if (accept) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    // Datapath pipeline registers, pointers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            g_q         <= '0;
            d_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            wp_q        <= '0;
            clr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == S_CLEAR) begin
                clr_q <= clr_q + AW'(1);
            end
            if (accept) begin
                x_q <= in;
                g_q <= shadow_g_q;
            end
            if (state_q == S_READ) begin
                d_q <= rd_dat_q;
            end
            if (state_q == S_MUL1) begin
                y_q <= y_calc;
            end
            if (state_q == S_MUL2) begin
                p_q <= prod_sat;
            end
            if (state_q == S_WRITE) begin
                wp_q        <= wp_q + AW'(1);
                out_q       <= y_q;
                out_valid_q <= 1'b1;
            end
            // Samples arriving mid-computation are lost; CLEAR drops them quietly.
            if (sample_en && (state_q != S_IDLE) && (state_q != S_CLEAR)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_allpass_filter.sv
// Testbench for allpass_filter: directed and random samples against a sample-level reference model.
// Latency: expects out_valid exactly 4 clocks after each accepted sample_en.
// Backpressure: exercises dropped samples during CLEAR and overrun during computation.

module tb_allpass_filter;

    localparam int WIDTH    = 12;
    localparam int FRAC     = 12;
    localparam int MAXDELAY = 16;
    localparam int WORD     = WIDTH + FRAC;

    localparam longint ONE  = longint'(1) <<< FRAC;
    localparam longint WMAX = (longint'(1) <<< (WORD - 1)) - 1;
    localparam longint WMIN = -(longint'(1) <<< (WORD - 1));

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sample_en = 1'b0;
    logic            write = 1'b0;
    logic [WORD-1:0] in_d = '0;
    logic [WORD-1:0] tau_d = '0;
    logic [WORD-1:0] gain_d = '0;
    logic [WORD-1:0] out_w;
    logic            out_valid;
    logic            busy;
    logic            overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state: every v ever pushed since the last clear, plus shadow config.
    longint hist[$];
    longint sh_t = 1;
    longint sh_g = 0;

    allpass_filter #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .MAXDELAY (MAXDELAY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .in        (in_d),
        .tau       (tau_d),
        .gain      (gain_d),
        .write     (write),
        .out       (out_w),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    function automatic longint mq(input longint g, input longint x);
        longint p;
        p = (g * x) >>> FRAC;
        return sat(p);
    endfunction

    // One audio sample through the all-pass equations; delay line is the full history.
    task automatic model_step(input longint x, output longint y);
        longint d, v;
        int     idx;
        idx = hist.size() - int'(sh_t);
        d   = (idx >= 0) ? hist[idx] : 0;
        y   = sat(d - mq(sh_g, x));
        v   = sat(x + mq(sh_g, y));
        hist.push_back(v);
    endtask

    task automatic set_shadow(input longint t, input longint g);
        if (t < 1) sh_t = 1;
        else if (t > MAXDELAY) sh_t = MAXDELAY;
        else sh_t = t;
        sh_g = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc, input string tag);
        int n;
        bit saw_v;
        bit saw_out;
        rst = 1'b1;
        sample_en = 1'b0;
        write = 1'b0;
        repeat (ncyc) tick();
        rst = 1'b0;
        hist.delete();
        sh_t = 1;
        sh_g = 0;
        chk({tag, "_out"}, $signed(out_w), 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_overrun"}, overrun, 0);
        n = 0;
        saw_v = 1'b0;
        saw_out = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            sample_en = (n == 5);
            tick();
            n++;
            if (out_valid !== 1'b0) saw_v = 1'b1;
            if (out_w !== '0) saw_out = 1'b1;
        end
        sample_en = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid !== 1'b0) saw_v = 1'b1;
            if (busy !== 1'b0) saw_v = 1'b1;
        end
        chk({tag, "_busy_len"}, n, MAXDELAY);
        chk({tag, "_no_valid"}, saw_v, 0);
        chk({tag, "_out_zero"}, saw_out, 0);
        chk({tag, "_overrun_clr"}, overrun, 0);
    endtask

    task automatic cfg(input longint t, input longint g);
        tau_d  = WORD'(t);
        gain_d = WORD'(g);
        write  = 1'b1;
        tick();
        write  = 1'b0;
        set_shadow(t, g);
    endtask

    // Send one sample; optionally a second strobe 'extra' edges later and a same-edge config write.
    task automatic send(input longint x, input int extra, input bit wr, input longint wt, input longint wg,
                        input string tag);
        longint yexp;
        int     lat;
        model_step(x, yexp);
        in_d = WORD'(x);
        sample_en = 1'b1;
        if (wr) begin
            tau_d  = WORD'(wt);
            gain_d = WORD'(wg);
            write  = 1'b1;
        end
        tick();
        sample_en = 1'b0;
        write = 1'b0;
        if (wr) set_shadow(wt, wg);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            sample_en = (extra != 0) && (lat + 1 == extra);
            if (sample_en) in_d = WORD'($urandom);
            tick();
            lat++;
        end
        sample_en = 1'b0;
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_y"}, $signed(out_w), yexp);
        tick();
        chk({tag, "_pulse"}, out_valid, 0);
        chk({tag, "_hold"}, $signed(out_w), yexp);
        tick();
        tick();
    endtask

    initial begin
        longint ap_exp[5] = '{-2048, 3072, 1536, 768, 384};
        logic signed [WORD-1:0] r;
        longint t;
        longint g;

        // Reset and delay-line clear, with a dropped strobe during CLEAR
        do_reset(2, "rst0");

        // Pure delay of 3 samples
        cfg(3, 0);
        for (int i = 0; i < 6; i++) begin
            send((i == 0) ? ONE : 0, 0, 1'b0, 0, 0, "pd");
            chk("pd_const", $signed(out_w), (i == 3) ? ONE : 0);
        end

        // All-pass impulse response, g = 0.5
        do_reset(2, "rst1");
        cfg(1, ONE / 2);
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? ONE : 0, 0, 1'b0, 0, 0, "ap");
            chk("ap_const", $signed(out_w), ap_exp[i]);
        end

        // Saturation: stored max, then g = -1.0 pushes y past full scale
        do_reset(2, "rst2");
        cfg(1, 0);
        send(WMAX, 0, 1'b0, 0, 0, "sat0");
        cfg(1, -ONE);
        send(WMAX, 0, 1'b0, 0, 0, "sat1");
        chk("sat_const", $signed(out_w), WMAX);
        send(WMIN, 0, 1'b0, 0, 0, "sat2");
        send(WMIN, 0, 1'b0, 0, 0, "sat3");

        // Strobe on the WRITE->IDLE edge is an overrun, not a new sample
        do_reset(2, "rst3");
        cfg(1, 0);
        send(100, 4, 1'b0, 0, 0, "ov4");
        chk("ov4_flag", overrun, 1);
        send(200, 0, 1'b0, 0, 0, "ov4b");
        chk("ov4b_const", $signed(out_w), 100);

        // Strobe 2 clocks into a sample, then a config write on an accepted edge
        do_reset(2, "rst4");
        cfg(1, 0);
        send(300, 2, 1'b0, 0, 0, "ov2");
        chk("ov2_flag", overrun, 1);
        send(ONE, 0, 1'b1, 1, ONE / 2, "wr_old");
        chk("wr_old_const", $signed(out_w), 300);
        send(ONE, 0, 1'b0, 0, 0, "wr_new");
        chk("wr_new_const", $signed(out_w), ONE / 2);
        chk("ov_sticky", overrun, 1);

        // Clamp: tau=0 acts as 1, tau=MAXDELAY+5 acts as MAXDELAY across the pointer wrap
        do_reset(2, "rst5");
        cfg(0, 0);
        for (int i = 0; i < 3; i++) begin
            send((i == 0) ? ONE : 0, 0, 1'b0, 0, 0, "cl0");
            chk("cl0_const", $signed(out_w), (i == 1) ? ONE : 0);
        end
        cfg(MAXDELAY + 5, 0);
        for (int i = 0; i < 18; i++) begin
            send((i == 0) ? ONE : 0, 0, 1'b0, 0, 0, "clm");
            chk("clm_const", $signed(out_w), (i == 13 || i == 16) ? ONE : 0);
        end

        // Random configurations and samples
        do_reset(2, "rst6");
        for (int k = 0; k < 6; k++) begin
            t = longint'($urandom_range(20));
            g = longint'($urandom_range(2 * ONE)) - ONE;
            cfg(t, g);
            for (int i = 0; i < 8; i++) begin
                r = WORD'($urandom);
                send(longint'(r), 0, 1'b0, 0, 0, "rnd");
            end
        end

        // Reset during MUL1 discards the sample and restarts CLEAR
        in_d = WORD'(ONE);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        chk("mid_busy", busy, 1);
        do_reset(1, "midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
